tpu_sequencer: RTL

Front-end controller between the 16-bit pin-level instruction bus and the NxN systolic multiply array. It decodes instructions and generates one-cycle operand-buffer write strobes. It also sequences timed matrix-multiply runs and steers the 8-bit result output mux. Because pins are level-held, new instructions are detected by toggling a tag bit, which makes repeated sampling harmless.

---
 rtl/tpu_pkg.sv | 38 +++
 rtl/tpu_instr_decode.sv | 34 +++
 rtl/tpu_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU front-end sequencer: instruction layout, opcodes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpu_pkg;

    // Default array dimension (NxN); legal values 2..4
    localparam int N_DEF = 2;

    // Instruction word layout: [15] tag, [14:12] opcode, [11:10] row, [9:8] col, [7:0] data
    localparam int INSTR_W  = 16;
    localparam int TAG_BIT  = 15;
    localparam int OP_MSB   = 14;
    localparam int OP_LSB   = 12;
    localparam int ROW_MSB  = 11;
    localparam int ROW_LSB  = 10;
    localparam int COL_MSB  = 9;
    localparam int COL_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_LOAD_A = 3'b001,
        OP_LOAD_B = 3'b010,
        OP_CLEAR  = 3'b011,
        OP_RUN    = 3'b100,
        OP_READ   = 3'b101,
        OP_STATUS = 3'b110,
        OP_RSVD   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tpu_instr_decode.sv
// Combinational decode of the registered pin word into accept, one-hot opcode and range check.
// Latency: 0 (pure combinational).
// Backpressure: accept is gated by idle, so a new tag simply waits in instr_q while the sequencer is busy.
// TPU_SEQ_STATUS_EN: when undefined the STATUS opcode decodes as a NOP.
module tpu_instr_decode
    import tpu_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [INSTR_W-1:0] instr_q,
    input  logic               last_tag,
    input  logic               idle,
    output logic               accept,
    output logic [7:0]         op_hot,
    output logic               range_ok,
    output logic [1:0]         row,
    output logic [1:0]         col,
    output logic [7:0]         data
);

    // Split fields, build the one-hot opcode and qualify acceptance by tag change and idle state
    always_comb begin
        row      = instr_q[ROW_MSB:ROW_LSB];
        col      = instr_q[COL_MSB:COL_LSB];
        data     = instr_q[DATA_MSB:DATA_LSB];
        op_hot   = 8'd1 << instr_q[OP_MSB:OP_LSB];
`ifndef TPU_SEQ_STATUS_EN
        op_hot[OP_STATUS] = 1'b0;
`endif
        range_ok = (int'(row) < N) && (int'(col) < N);
        accept   = idle && (instr_q[TAG_BIT] != last_tag);
    end

endmodule

// File: rtl/tpu_sequencer.sv
// Pin-level instruction front end for the NxN systolic array: operand strobes, timed RUNs, result mux select.
// Latency: pin change to strobe 2 clk; a RUN holds arr_en for RUN_CYCLES clk, then one done cycle.
// Backpressure: none on pins; a new tag is held in instr_q during RUN/DONE and taken on the first idle cycle.
// TPU_SEQ_STATUS_EN: adds a sticky status mode (set by STATUS, cleared by READ) and the status_byte port.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 16,
    parameter int RUN_CYCLES = 3*N-2
) (
`ifdef TPU_SEQ_STATUS_EN
    output logic [7:0]        status_byte,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instruction,
    output logic              a_we,
    output logic              b_we,
    output logic [1:0]        wr_row,
    output logic [1:0]        wr_col,
    output logic [DATA_W-1:0] wr_data,
    output logic              acc_clr,
    output logic              arr_en,
    output logic [3:0]        step,
    output logic [1:0]        out_row,
    output logic [1:0]        out_col,
    output logic              out_hi,
    output logic              busy,
    output logic              done
);

    // The high-byte select only means something when the accumulator is wider than one operand
    localparam bit         HAS_HI    = (ACC_W > DATA_W);
    localparam logic [3:0] STEP_LAST = 4'(RUN_CYCLES - 1);

    logic [INSTR_W-1:0] instr_q;
    logic               last_tag;
    state_e             state;
    state_e             state_nxt;
    logic [3:0]         step_nxt;
    logic               run_last;

    logic               accept;
    logic [7:0]         op_hot;
    logic               range_ok;
    logic [1:0]         f_row;
    logic [1:0]         f_col;
    logic [7:0]         f_data;

    logic               do_load_a;
    logic               do_load_b;
    logic               do_read;
    logic               unused_op;

    tpu_instr_decode #(
        .N (N)
    ) u_decode (
        .instr_q  (instr_q),
        .last_tag (last_tag),
        .idle     (state == S_IDLE),
        .accept   (accept),
        .op_hot   (op_hot),
        .range_ok (range_ok),
        .row      (f_row),
        .col      (f_col),
        .data     (f_data)
    );

    // Row/col fields only matter to the opcodes that address an element; out-of-range ones are dropped
    assign do_load_a = accept & op_hot[OP_LOAD_A] & range_ok;
    assign do_load_b = accept & op_hot[OP_LOAD_B] & range_ok;
    assign do_read   = accept & op_hot[OP_READ]   & range_ok;
    assign run_last  = (step == STEP_LAST);
    assign unused_op = ^{op_hot[OP_NOP], op_hot[OP_RSVD], op_hot[OP_STATUS]};

    // Sample the level-held pins every cycle and remember the tag of the last consumed instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            last_tag <= 1'b0;
        end else begin
            instr_q <= instruction;
            if (accept) begin
                last_tag <= instr_q[TAG_BIT];
            end
        end
    end

    // FSM state and feed-step registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next state, step count and the state-decoded run outputs
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        busy      = 1'b0;
        arr_en    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && op_hot[OP_RUN]) begin
                    state_nxt = S_RUN;
                    step_nxt  = '0;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                arr_en = 1'b1;
                if (run_last) begin
                    state_nxt = S_DONE;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + 4'd1;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    // One-cycle strobes plus write fields that hold their value between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_we    <= 1'b0;
            b_we    <= 1'b0;
            acc_clr <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
        end else begin
            a_we    <= do_load_a;
            b_we    <= do_load_b;
            acc_clr <= accept & op_hot[OP_CLEAR];
            if (do_load_a || do_load_b) begin
                wr_row  <= f_row;
                wr_col  <= f_col;
                wr_data <= f_data[DATA_W-1:0];
            end
        end
    end

    // Result mux select, held until the next in-range READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row <= '0;
            out_col <= '0;
            out_hi  <= 1'b0;
        end else if (do_read) begin
            out_row <= f_row;
            out_col <= f_col;
            out_hi  <= HAS_HI & f_data[0];
        end
    end

`ifdef TPU_SEQ_STATUS_EN
    logic       status_mode;
    logic       done_seen;
    logic [3:0] run_count;

    // Sticky status mode and completed-RUN bookkeeping; any accepted READ leaves status mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_mode <= 1'b0;
            done_seen   <= 1'b0;
            run_count   <= '0;
        end else begin
            if (accept && op_hot[OP_STATUS]) begin
                status_mode <= 1'b1;
            end else if (accept && op_hot[OP_READ]) begin
                status_mode <= 1'b0;
            end
            if (state == S_RUN && run_last) begin
                run_count <= run_count + 4'd1;
                done_seen <= 1'b1;
            end
        end
    end

    assign status_byte = status_mode ? {busy, done_seen, last_tag, 1'b0, run_count} : 8'h00;
`endif

endmodule
